// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the bin_to_bcd shift-and-add-3 converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_NINE = 4'b1001;

  // Largest value representable in the given number of decimal digits.
  function automatic int unsigned bcd_max_value(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble correction cell: digits of 5 or more get +3 before the shift.
module bcd_add3 (
  input  logic [3:0] value,
  output logic [3:0] adjusted
);

  assign adjusted = (value >= 4'd5) ? (value + 4'd3) : value;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
// Optional build macro BIN_TO_BCD_SAT_EN: saturate bcd to all nines on overflow.
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
  localparam int unsigned   MAX_BIN    = bcd_max_value(DIGITS);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_BIN[WIDTH-1:0];

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   shift_q;
  logic [BCD_W-1:0]   work_q;
  logic [CW-1:0]      count_q;
  logic               ovf_pending_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               overflow_q;

  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_shifted;
  logic [BCD_W-1:0]   result;
  logic               last_shift;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3 u_add3 (
      .value    (work_q[4*d +: 4]),
      .adjusted (work_adj[4*d +: 4])
    );
  end

  // The carry out of the top digit falls off here, leaving bin mod 10^DIGITS.
  assign work_shifted = {work_adj[BCD_W-2:0], shift_q[WIDTH-1]};

`ifdef BIN_TO_BCD_SAT_EN
  assign result = ovf_pending_q ? {DIGITS{BCD_NINE}} : work_shifted;
`else
  assign result = work_shifted;
`endif

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    last_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (count_q == LAST_COUNT) begin
          last_shift = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers load on the edge entering DONE so they change together with done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      work_q        <= '0;
      count_q       <= '0;
      ovf_pending_q <= 1'b0;
      bcd_q         <= '0;
      overflow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q       <= bin;
            work_q        <= '0;
            count_q       <= '0;
            ovf_pending_q <= (bin > MAX_VAL);
          end
        end
        SHIFT: begin
          shift_q <= {shift_q[WIDTH-2:0], 1'b0};
          work_q  <= work_shifted;
          count_q <= count_q + CW'(1);
          if (last_shift) begin
            bcd_q      <= result;
            overflow_q <= ovf_pending_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd.sv
// Directed, table-driven bench for bin_to_bcd (WIDTH=14, DIGITS=4).
module tb_bin_to_bcd;

  localparam int WIDTH  = 14;
  localparam int DIGITS = 4;

  logic                clk;
  logic                reset_n;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic                overflow;

  int checks;
  int failures;
  logic [15:0] prev_bcd;

  typedef struct {
    logic [WIDTH-1:0] value;
    logic [15:0]      exp_bcd;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[9];

  bin_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Pulses start at a negedge so it is accepted on the next rising edge (cycle 0),
  // then walks cycles 1..WIDTH+2 checking handshake, output hold and result.
  task automatic applyStimulus(input logic [WIDTH-1:0] value, input logic [15:0] exp_bcd,
                               input logic exp_ovf, input int glitch_cycle,
                               input logic [WIDTH-1:0] glitch_bin, input string tag);
    @(negedge clk);
    bin   = value;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bin   = ~value;
    for (int k = 1; k <= WIDTH; k++) begin
      checkOutput({tag, " busy"}, 16'(busy), 16'd1);
      checkOutput({tag, " done_low"}, 16'(done), 16'd0);
      checkOutput({tag, " bcd_hold"}, bcd, prev_bcd);
      if (glitch_cycle != 0 && k == glitch_cycle - 1) begin
        start = 1'b1;
        bin   = glitch_bin;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput({tag, " done"}, 16'(done), 16'd1);
    checkOutput({tag, " busy_in_done"}, 16'(busy), 16'd0);
    checkOutput({tag, " bcd"}, bcd, exp_bcd);
    checkOutput({tag, " overflow"}, 16'(overflow), 16'(exp_ovf));
    prev_bcd = exp_bcd;
    @(negedge clk);
    checkOutput({tag, " done_pulse_end"}, 16'(done), 16'd0);
    checkOutput({tag, " bcd_stable"}, bcd, exp_bcd);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    prev_bcd = 16'h0000;
    reset_n  = 1'b0;
    start    = 1'b0;
    bin      = '0;

`ifdef BIN_TO_BCD_SAT_EN
    vecs[0] = '{14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd12345, 16'h9999, 1'b1};
    vecs[4] = '{14'd1000,  16'h1000, 1'b0};
    vecs[5] = '{14'd10000, 16'h9999, 1'b1};
    vecs[6] = '{14'd5,     16'h0005, 1'b0};
    vecs[7] = '{14'd16383, 16'h9999, 1'b1};
    vecs[8] = '{14'd8197,  16'h8197, 1'b0};
`else
    vecs[0] = '{14'd1234,  16'h1234, 1'b0};
    vecs[1] = '{14'd0,     16'h0000, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd12345, 16'h2345, 1'b1};
    vecs[4] = '{14'd1000,  16'h1000, 1'b0};
    vecs[5] = '{14'd10000, 16'h0000, 1'b1};
    vecs[6] = '{14'd5,     16'h0005, 1'b0};
    vecs[7] = '{14'd16383, 16'h6383, 1'b1};
    vecs[8] = '{14'd8197,  16'h8197, 1'b0};
`endif

    repeat (3) @(negedge clk);
    checkOutput("reset busy", 16'(busy), 16'd0);
    checkOutput("reset done", 16'(done), 16'd0);
    checkOutput("reset bcd", bcd, 16'h0000);
    checkOutput("reset overflow", 16'(overflow), 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].value, vecs[i].exp_bcd, vecs[i].exp_ovf, 0, '0,
                    $sformatf("vec%0d", i));
    end

    // start held high: accepted every WIDTH+2 cycles, ignored in DONE
    @(negedge clk);
    bin   = 14'd42;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 47; c++) begin
      @(negedge clk);
      checkOutput($sformatf("held c%0d done", c), 16'(done), 16'((c % 16) == 15));
    end
    checkOutput("held bcd", bcd, 16'h0042);
    checkOutput("held overflow", 16'(overflow), 16'd0);
    start    = 1'b0;
    prev_bcd = 16'h0042;
    @(negedge clk);

    applyStimulus(14'd5678, 16'h5678, 1'b0, 5, 14'd1111, "ignored_start");

    // reset mid-conversion abandons the result
    @(negedge clk);
    bin   = 14'd321;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset busy", 16'(busy), 16'd0);
    checkOutput("midreset done", 16'(done), 16'd0);
    checkOutput("midreset bcd", bcd, 16'h0000);
    checkOutput("midreset overflow", 16'(overflow), 16'd0);
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checkOutput($sformatf("midreset c%0d no_done", c), 16'(done), 16'd0);
    end
    prev_bcd = 16'h0000;
    applyStimulus(14'd321, 16'h0321, 1'b0, 0, '0, "after_reset");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
